// File: rtl/ps2_note_synth.sv
// PS/2 scan-code parser driving a monophonic square-wave tone generator (C4..C5).
// Latency: note state updates on the byte-strobe edge; channel samples are registered, one cycle behind note/polarity.
// Backpressure: none held; write_audio_out mirrors audio_out_allowed and the phase advances only on accepted samples.
//
// Ports:
//   CLOCK_50, reset (sync, active-high)
//   ps2_data[7:0] + ps2_data_en : received byte with one-cycle strobe
//   audio_out_allowed / write_audio_out : codec sample handshake
//   left/right_channel_audio_out[31:0] : signed sample, identical on both channels
//   note_active, note_index[2:0] : currently held note (0 = C4 .. 7 = C5)
module ps2_note_synth #(
    parameter logic [31:0] AMPLITUDE = 32'h1000_0000
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [7:0]  ps2_data,
    input  logic        ps2_data_en,
    input  logic        audio_out_allowed,
    output logic        write_audio_out,
    output logic [31:0] left_channel_audio_out,
    output logic [31:0] right_channel_audio_out,
    output logic        note_active,
    output logic [2:0]  note_index
);

    localparam logic [31:0] AMP_NEG = ~AMPLITUDE + 32'd1;

    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        is_make;
    logic        is_brk;
    logic        key_hit;
    logic [2:0]  key_note;
    logic [6:0]  half_period;
    logic [6:0]  phase_cnt;
    logic        polarity;      // 0 = positive half-cycle
    logic [31:0] sample;
    logic        new_note;
    logic        end_note;
    logic        accept;

    // Parser state register
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Parser next state; extended sequences complete without raising make/break
    always_comb begin
        state_nxt = state;
        is_make   = 1'b0;
        is_brk    = 1'b0;
        if (ps2_data_en) begin
            case (state)
                IDLE: begin
                    if (ps2_data == 8'hF0)      state_nxt = BRK;
                    else if (ps2_data == 8'hE0) state_nxt = EXT;
                    else                        is_make   = 1'b1;
                end
                BRK: begin
                    is_brk    = 1'b1;
                    state_nxt = IDLE;
                end
                EXT: begin
                    state_nxt = (ps2_data == 8'hF0) ? EXT_BRK : IDLE;
                end
                EXT_BRK: begin
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Scan code to note
    always_comb begin
        key_hit  = 1'b1;
        key_note = 3'd0;
        case (ps2_data)
            8'h1C:   key_note = 3'd0;
            8'h1B:   key_note = 3'd1;
            8'h23:   key_note = 3'd2;
            8'h2B:   key_note = 3'd3;
            8'h34:   key_note = 3'd4;
            8'h33:   key_note = 3'd5;
            8'h3B:   key_note = 3'd6;
            8'h42:   key_note = 3'd7;
            default: key_hit  = 1'b0;
        endcase
    end

    // Half-period in samples at 48 kHz for the current note
    always_comb begin
        case (note_index)
            3'd0:    half_period = 7'd92;
            3'd1:    half_period = 7'd82;
            3'd2:    half_period = 7'd73;
            3'd3:    half_period = 7'd69;
            3'd4:    half_period = 7'd61;
            3'd5:    half_period = 7'd55;
            3'd6:    half_period = 7'd49;
            default: half_period = 7'd46;
        endcase
    end

    assign accept   = audio_out_allowed;
    // A repeat of the held note (typematic) must not restart the phase
    assign new_note = is_make && key_hit && (!note_active || (key_note != note_index));
    // Only releasing the most recently pressed key silences the tone
    assign end_note = is_brk && key_hit && note_active && (key_note == note_index);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            note_active <= 1'b0;
            note_index  <= 3'd0;
            phase_cnt   <= 7'd0;
            polarity    <= 1'b0;
            sample      <= 32'd0;
        end else begin
            sample <= note_active ? (polarity ? AMP_NEG : AMPLITUDE) : 32'd0;
            if (new_note) begin
                note_active <= 1'b1;
                note_index  <= key_note;
                phase_cnt   <= 7'd0;
                polarity    <= 1'b0;
            end else if (end_note || !note_active) begin
                note_active <= 1'b0;
                phase_cnt   <= 7'd0;
                polarity    <= 1'b0;
            end else if (accept) begin
                if (phase_cnt == half_period - 7'd1) begin
                    phase_cnt <= 7'd0;
                    polarity  <= ~polarity;
                end else begin
                    phase_cnt <= phase_cnt + 7'd1;
                end
            end
        end
    end

    assign write_audio_out         = audio_out_allowed;
    assign left_channel_audio_out  = sample;
    assign right_channel_audio_out = sample;

endmodule

// File: tb/tb_ps2_note_synth.sv
// Testbench for ps2_note_synth: directed key sequences plus random bytes/handshake,
// compared every cycle against a sequence-level reference model of the tone.
module tb_ps2_note_synth;

    localparam logic [31:0] AMP = 32'h1000_0000;

    logic        clk;
    logic        reset;
    logic [7:0]  ps2_data;
    logic        ps2_data_en;
    logic        audio_out_allowed;
    logic        write_audio_out;
    logic [31:0] left_out;
    logic [31:0] right_out;
    logic        note_active;
    logic [2:0]  note_index;

    int checks   = 0;
    int failures = 0;

    ps2_note_synth #(.AMPLITUDE(AMP)) dut (
        .CLOCK_50               (clk),
        .reset                  (reset),
        .ps2_data               (ps2_data),
        .ps2_data_en            (ps2_data_en),
        .audio_out_allowed      (audio_out_allowed),
        .write_audio_out        (write_audio_out),
        .left_channel_audio_out (left_out),
        .right_channel_audio_out(right_out),
        .note_active            (note_active),
        .note_index             (note_index)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int         hp_tab [8] = '{92, 82, 73, 69, 61, 55, 49, 46};
    bit         m_on     = 1'b0;
    bit         m_active = 1'b0;
    int         m_idx    = 0;
    int         m_n      = 0;     // accepted samples since note start
    logic [7:0] m_pre[$];         // prefix bytes (E0/F0) of the code in progress

    function automatic int note_of(input logic [7:0] b);
        case (b)
            8'h1C: return 0;
            8'h1B: return 1;
            8'h23: return 2;
            8'h2B: return 3;
            8'h34: return 4;
            8'h33: return 5;
            8'h3B: return 6;
            8'h42: return 7;
            default: return -1;
        endcase
    endfunction

    always @(posedge clk) begin
        logic [31:0] exp_s;
        bit          ev;
        bit          has_e0;
        bit          has_f0;
        int          k;
        // Sample register reflects the state held before this edge
        if (reset || !m_active)             exp_s = 32'd0;
        else if (((m_n / hp_tab[m_idx]) % 2) == 1) exp_s = -AMP;
        else                                exp_s = AMP;

        ev = 1'b0;
        if (reset) begin
            m_on = 1'b1; m_active = 1'b0; m_idx = 0; m_n = 0;
            m_pre.delete();
        end else begin
            if (ps2_data_en) begin
                if (m_pre.size() == 0 && (ps2_data == 8'hF0 || ps2_data == 8'hE0)) begin
                    m_pre.push_back(ps2_data);
                end else if (m_pre.size() == 1 && m_pre[0] == 8'hE0 && ps2_data == 8'hF0) begin
                    m_pre.push_back(ps2_data);
                end else begin
                    has_e0 = 1'b0; has_f0 = 1'b0;
                    foreach (m_pre[i]) begin
                        if (m_pre[i] == 8'hE0) has_e0 = 1'b1;
                        if (m_pre[i] == 8'hF0) has_f0 = 1'b1;
                    end
                    m_pre.delete();
                    k = note_of(ps2_data);
                    if (!has_e0 && k >= 0) begin
                        if (!has_f0 && (!m_active || k != m_idx)) begin
                            m_active = 1'b1; m_idx = k; m_n = 0; ev = 1'b1;
                        end else if (has_f0 && m_active && k == m_idx) begin
                            m_active = 1'b0; m_n = 0; ev = 1'b1;
                        end
                    end
                end
            end
            if (!ev && m_active && audio_out_allowed) m_n++;
        end

        #1;
        if (m_on) begin
            check("left", left_out, exp_s);
            check("right", right_out, exp_s);
            check("note_active", {31'd0, note_active}, {31'd0, m_active});
            if (m_active) check("note_index", {29'd0, note_index}, m_idx[31:0]);
            check("write", {31'd0, write_audio_out}, {31'd0, audio_out_allowed});
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        ps2_data    = b;
        ps2_data_en = 1'b1;
        @(negedge clk);
        ps2_data_en = 1'b0;
    endtask

    task automatic send_b2b(input logic [7:0] b1, input logic [7:0] b2);
        @(negedge clk);
        ps2_data = b1; ps2_data_en = 1'b1;
        @(negedge clk);
        ps2_data = b2;
        @(negedge clk);
        ps2_data_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [7:0] pick_tab [14] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B,
                                  8'h42, 8'hF0, 8'hF0, 8'hE0, 8'h12, 8'hF0, 8'h1C};

    initial begin
        int pos_cnt;
        int neg_cnt;
        reset = 1'b1; ps2_data = 8'h00; ps2_data_en = 1'b0; audio_out_allowed = 1'b0;
        idle(3);
        check("rst_left", left_out, 32'd0);
        check("rst_active", {31'd0, note_active}, 32'd0);
        check("rst_index", {29'd0, note_index}, 32'd0);
        reset = 1'b0;

        // Idle with codec always ready
        audio_out_allowed = 1'b1;
        idle(20);
        check("idle_left", left_out, 32'd0);
        check("idle_write", {31'd0, write_audio_out}, 32'd1);

        // Note C4: 92 positive, 92 negative, then positive again
        send_byte(8'h1C);
        check("c4_active", {31'd0, note_active}, 32'd1);
        check("c4_index", {29'd0, note_index}, 32'd0);
        check("c4_first_sample", left_out, 32'd0);
        pos_cnt = 0; neg_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #2;
            if (left_out == 32'h1000_0000) pos_cnt++;
            if (left_out == 32'hF000_0000) neg_cnt++;
        end
        check("c4_pos_count", pos_cnt, 32'd108);
        check("c4_neg_count", neg_cnt, 32'd92);

        // Switch to C5, release of older key ignored
        send_byte(8'h42);
        send_b2b(8'hF0, 8'h1C);
        idle(100);
        check("c5_index", {29'd0, note_index}, 32'd7);
        check("c5_active", {31'd0, note_active}, 32'd1);

        // Release C5
        send_b2b(8'hF0, 8'h42);
        check("rel_active", {31'd0, note_active}, 32'd0);
        idle(3);
        check("rel_left", left_out, 32'd0);

        // Extended codes while F held
        send_byte(8'h2B);
        idle(10);
        send_b2b(8'hE0, 8'h1C);
        @(negedge clk);
        ps2_data = 8'hE0; ps2_data_en = 1'b1;
        @(negedge clk); ps2_data = 8'hF0;
        @(negedge clk); ps2_data = 8'h42;
        @(negedge clk); ps2_data_en = 1'b0;
        idle(5);
        check("ext_index", {29'd0, note_index}, 32'd3);
        check("ext_active", {31'd0, note_active}, 32'd1);

        // Note A4 with alternating handshake
        send_byte(8'h33);
        for (int i = 0; i < 240; i++) begin
            @(negedge clk);
            audio_out_allowed = ~audio_out_allowed;
        end
        audio_out_allowed = 1'b1;

        // Reset drops a pending F0; next 33 is a make
        send_byte(8'hF0);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        send_byte(8'h33);
        check("rst_mid_active", {31'd0, note_active}, 32'd1);
        check("rst_mid_index", {29'd0, note_index}, 32'd5);
        idle(120);

        // Random bytes, handshake and occasional reset
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            audio_out_allowed = ($urandom_range(0, 3) != 0);
            reset             = ($urandom_range(0, 799) == 0);
            if ($urandom_range(0, 9) == 0) begin
                ps2_data    = pick_tab[$urandom_range(0, 13)];
                ps2_data_en = 1'b1;
            end else begin
                ps2_data_en = 1'b0;
            end
        end
        @(negedge clk);
        reset = 1'b0; ps2_data_en = 1'b0;
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
